// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: oversampled 8N1 UART receiver feeding a byte FIFO
//   clock_uart  in   OVERSAMPLE x baud clock        reset_n     in   async active-low reset
//   rx1         in   async serial line, idle high   rx_ready    in   consumer accept (pop)
//   rx_data     out  FIFO head byte                 rx_valid    out  FIFO not empty
//   frame_err   out  pulse on low stop bit          overrun     out  pulse on byte dropped (FIFO full)
//   fifo_count  out  bytes held                     busy        out  receiver not idle
module uart_cmd_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock_uart,
  input  logic                          reset_n,
  input  logic                          rx1,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic rx_s, push, pop, wr;
  assign rx_s = sync_q[1];
  assign rx_valid = count_q != '0;
  assign rx_data = mem_q[rptr_q];
  assign fifo_count = count_q;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
  assign busy = state_q != IDLE;
  always_comb begin
    sync_d = {sync_q[0], rx1};
    state_d = state_q;
    tick_d = tick_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    push = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (tick_q == T_MID) begin
        tick_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick_q == T_LAST) begin
        tick_d = '0;
        shift_d[idx_q] = rx_s;
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (tick_q == T_LAST) begin
        tick_d = '0;
        push = rx_s;
        frame_err_d = !rx_s;
        state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        tick_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    pop = rx_valid && rx_ready;
    wr = push && (count_q != FULL || pop);
    overrun_d = push && count_q == FULL && !pop;
    mem_d = mem_q;
    if (wr) mem_d[wptr_q] = shift_q;
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    count_d = count_q + (AW + 1)'(wr) - (AW + 1)'(pop);
  end
  always_ff @(posedge clock_uart or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      tick_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      mem_q <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      tick_q <= tick_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: randomized self-checking bench for uart_cmd_rx against a queue model
module tb_uart_cmd_rx;
  localparam int OS = 16;
  localparam int D = 8;
  localparam int PUSH_C = 9 * OS + OS / 2 + 3;
  logic clock_uart = 1'b0;
  logic reset_n = 1'b0;
  logic rx1 = 1'b1;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  logic [$clog2(D):0] fifo_count;
  uart_cmd_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(D)) dut (
    .clock_uart(clock_uart),
    .reset_n(reset_n),
    .rx1(rx1),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .fifo_count(fifo_count),
    .busy(busy)
  );
  always #5 clock_uart = ~clock_uart;
  int n_chk = 0, n_pass = 0;
  int fe_exp = 0, ov_exp = 0, fe_cnt = 0, ov_cnt = 0, valid_cycles = 0, max_count = 0;
  logic [7:0] model_q[$];
  logic [7:0] got_q[$];
  logic pv = 1'b0, pr = 1'b0, pfe = 1'b0, pov = 1'b0;
  logic [7:0] pd = 8'h00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  // Frame outcome by the receiver rules: good stop pushes unless full, bad stop flags.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) fe_exp++;
    else if (model_q.size() == D) ov_exp++;
    else model_q.push_back(b);
  endtask
  initial forever begin
    @(negedge clock_uart);
    #2;
    chk("count", fifo_count, model_q.size());
    chk("valid", rx_valid, model_q.size() != 0);
    chk("fe_width", frame_err & pfe, 0);
    chk("ov_width", overrun & pov, 0);
    if (pv && !pr && rx_valid) chk("hold", rx_data, pd);
    if (rx_valid && rx_ready) begin
      got_q.push_back(rx_data);
      if (model_q.size() != 0) chk("pop_data", rx_data, model_q.pop_front());
      else chk("pop_empty", rx_valid, 0);
    end
    fe_cnt += int'(frame_err);
    ov_cnt += int'(overrun);
    valid_cycles += int'(rx_valid);
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    pv = rx_valid;
    pr = rx_ready;
    pd = rx_data;
    pfe = frame_err;
    pov = overrun;
  end
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_data"}, rx_data, 0);
    chk({tag, "_fe"}, frame_err, 0);
    chk({tag, "_ov"}, overrun, 0);
  endtask
  task automatic idle(input int n, input int pct);
    rx1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (pct >= 0) rx_ready = $urandom_range(0, 99) < pct;
      @(negedge clock_uart);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit stop_ok, input int rdy_at, input int pct, input int rst_at);
    logic [9:0] fr;
    bit live;
    fr = {stop_ok, b, 1'b0};
    live = 1'b1;
    for (int c = 0; c < 10 * OS; c++) begin
      rx1 = fr[c / OS];
      if (pct >= 0) rx_ready = $urandom_range(0, 99) < pct;
      if (c == rdy_at) rx_ready = 1'b1;
      else if (c == rdy_at + 1) rx_ready = 1'b0;
      if (c == rst_at) begin
        reset_n = 1'b0;
        model_q.delete();
        live = 1'b0;
      end
      if (c == rst_at + 3) begin
        chk_reset("midrst");
        reset_n = 1'b1;
      end
      if (c == PUSH_C && live) model_frame(b, stop_ok);
      @(negedge clock_uart);
    end
    if (!stop_ok) begin
      rx1 = 1'b0;
      repeat (3 * OS) @(negedge clock_uart);
      idle(2 * OS, pct);
    end
  endtask
  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 4 * D && model_q.size() != 0; i++) @(negedge clock_uart);
    repeat (2) @(negedge clock_uart);
    rx_ready = 1'b0;
    @(negedge clock_uart);
    chk("drained", fifo_count, 0);
  endtask
  initial begin
    int ov_before;
    repeat (3) @(negedge clock_uart);
    chk_reset("reset");
    reset_n = 1'b1;
    idle(20, -1);
    rx_ready = 1'b1;
    valid_cycles = 0;
    max_count = 0;
    got_q.delete();
    send(8'hA5, 1'b1, -10, -1, -10);
    idle(20, -1);
    chk("a5_n", got_q.size(), 1);
    if (got_q.size() != 0) chk("a5_data", got_q[0], 8'hA5);
    chk("a5_valid_cycles", valid_cycles, 1);
    chk("a5_max_count", max_count, 1);
    chk("a5_fe", fe_cnt, 0);
    rx1 = 1'b0;
    repeat (OS / 4) @(negedge clock_uart);
    rx1 = 1'b1;
    chk("glitch_busy", busy, 1);
    for (int i = 0; i < OS / 2 + 2 && busy; i++) @(negedge clock_uart);
    chk("glitch_idle", busy, 0);
    chk("glitch_count", fifo_count, 0);
    got_q.delete();
    send(8'h3C, 1'b0, -10, -1, -10);
    send(8'h55, 1'b1, -10, -1, -10);
    idle(20, -1);
    chk("brk_fe", fe_cnt, 1);
    chk("brk_n", got_q.size(), 1);
    if (got_q.size() != 0) chk("brk_data", got_q[0], 8'h55);
    rx_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i <= D; i++) begin
      send(8'(i), 1'b1, -10, -1, -10);
      idle(4, -1);
    end
    chk("full_count", fifo_count, D);
    chk("full_ov", ov_cnt, 1);
    drain();
    chk("full_n", got_q.size(), D);
    for (int i = 0; i < D && i < got_q.size(); i++) chk("full_order", got_q[i], i);
    got_q.delete();
    for (int i = 0; i < D; i++) begin
      send(8'h10 + 8'(i), 1'b1, -10, -1, -10);
      idle(4, -1);
    end
    ov_before = ov_cnt;
    send(8'h99, 1'b1, PUSH_C - 1, -1, -10);
    idle(4, -1);
    chk("same_ov", ov_cnt, ov_before);
    chk("same_count", fifo_count, D);
    drain();
    chk("same_n", got_q.size(), D + 1);
    if (got_q.size() == D + 1) begin
      chk("same_first", got_q[0], 8'h10);
      chk("same_last", got_q[D], 8'h99);
    end
    rx_ready = 1'b1;
    got_q.delete();
    send(8'hFF, 1'b1, -10, -1, 5 * OS + OS / 2);
    idle(20, -1);
    chk("rst_count", fifo_count, 0);
    chk("rst_n", got_q.size(), 0);
    send(8'h81, 1'b1, -10, -1, -10);
    idle(20, -1);
    chk("rst_next_n", got_q.size(), 1);
    if (got_q.size() != 0) chk("rst_next", got_q[0], 8'h81);
    for (int f = 0; f < 40; f++) begin
      int pct;
      pct = (f % 3 == 0) ? 100 : (f % 3 == 1) ? 50 : 3;
      send(8'($urandom), $urandom_range(0, 7) != 0, -10, pct, -10);
      idle($urandom_range(0, OS), pct);
    end
    drain();
    chk("fe_total", fe_cnt, fe_exp);
    chk("ov_total", ov_cnt, ov_exp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, clock_uart cycles per UART bit; the value shall be even and at least 8.
REQ-002 Parameter FIFO_DEPTH, default 8, receive FIFO entries; the value shall be a power of 2 and at least 2.
REQ-003 clock_uart  in  1  single clock for all logic, OVERSAMPLE x baud rate.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rx1  in  1  UART line from host; idle high; 8N1 framing, LSB first; asynchronous to clock_uart.
REQ-006 rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
REQ-007 rx_valid  out  1  high while the FIFO is not empty.
REQ-008 rx_ready  in  1  consumer accept; a pop occurs on a cycle where rx_valid=1 and rx_ready=1.
REQ-009 frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 overrun  out  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.
REQ-011 fifo_count  out  log2(FIFO_DEPTH)+1  number of bytes held, 0..FIFO_DEPTH.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 rx1 shall pass through a 2-flop synchronizer whose flops reset to 1; all sampling shall use the synchronized value rx_s.
REQ-014 States: IDLE, START, DATA, STOP, BREAK; a tick counter 0..OVERSAMPLE-1 and a bit index 0..7.
REQ-015 IDLE: when rx_s=0, go to START and clear the tick counter.
REQ-016 START: at tick OVERSAMPLE/2-1, go to DATA if rx_s=0 and restart the tick counter; if rx_s=1 (glitch), return to IDLE with no output.
REQ-017 DATA: sample rx_s at each tick OVERSAMPLE-1 into shift bit [index], LSB first; after index 7, go to STOP.
REQ-018 STOP: at tick OVERSAMPLE-1, if rx_s=1, push the byte and return to IDLE.
REQ-019 STOP: at tick OVERSAMPLE-1, if rx_s=0, pulse frame_err, discard the byte and go to BREAK.
REQ-020 BREAK: stay until rx_s=1, then go to IDLE; no start detection while in BREAK.
REQ-021 Push latency: the byte is written on the stop-sample cycle; rx_valid and fifo_count update on the next edge.
REQ-022 Push when fifo_count=FIFO_DEPTH with no pop that cycle: drop the byte, pulse overrun, leave FIFO contents unchanged.
REQ-023 Push and pop on the same cycle with the FIFO full: both occur, no overrun, fifo_count unchanged.
REQ-024 Push and pop on the same cycle otherwise: both occur, fifo_count unchanged.
REQ-025 Pop when empty: ignored, no underflow.
REQ-026 rx_data shall be the head entry combinationally from a registered read pointer; it shall stay stable while rx_valid=1 and rx_ready=0.
REQ-027 Read and write pointers wrap modulo FIFO_DEPTH; full and empty are derived from fifo_count.
REQ-028 frame_err and overrun pulses shall be exactly one cycle and never asserted while reset_n=0.

Reset
REQ-029 While reset_n=0: state IDLE, counters 0, FIFO empty, rx_valid=0, fifo_count=0, frame_err=0, overrun=0, busy=0, rx_data=0x00, synchronizer=1.
REQ-030 Reset asserted mid-frame aborts the frame with no push and no pulse.
REQ-031 After reset_n rises, the first falling edge of rx_s is detected as a start bit.

Verification
REQ-032 Byte 0xA5 sent with rx_ready=1 -> rx_data=0xA5, rx_valid high for 1 cycle, fifo_count 0->1->0, frame_err=0.
REQ-033 Low glitch of OVERSAMPLE/4 cycles on idle line -> back to IDLE, no push, busy falls within OVERSAMPLE/2+2 cycles.
REQ-034 0x3C sent with the stop bit forced low, held low 3 bit times, then 0x55 sent normally -> one frame_err pulse, no push for 0x3C, 0x55 received.
REQ-035 rx_ready=0, FIFO_DEPTH+1 bytes 0x00..0x08 sent -> fifo_count=8, one overrun pulse; draining yields 0x00..0x07 in order.
REQ-036 FIFO full, rx_ready asserted on the exact stop-sample cycle of the next byte -> no overrun, fifo_count stays 8, new byte is last in order.
REQ-037 reset_n pulsed low during bit 4 of 0xFF -> no push, FIFO empty; a following byte 0x81 is received correctly.
